// File: rtl/ysyx_23060236_rd_xbar.sv
// ysyx_23060236_rd_xbar
//
// Read-channel arbiter/router shared by the IFU (master 0) and the LSU
// (master 1). Only one read is in flight at a time. Round-robin picks the
// master, and the latched address picks the slave: CLINT (s1) or memory (s0).
//
// Ports
//   clock, reset             clock; asynchronous active-low reset
//   m{0,1}_ar{addr,valid}    master read address request
//   m{0,1}_arready           request accepted (only in IDLE)
//   m{0,1}_r{data,resp,valid} read data returned to the granted master
//   m{0,1}_rready            master ready for read data
//   s{0,1}_ar{addr,valid}    address to the selected slave
//   s{0,1}_arready           slave address ready
//   s{0,1}_r{data,resp,valid} slave read data
//   s{0,1}_rready            crossbar ready (mirrors granted master's rready)
//
// state | meaning
// IDLE  | arbitrate; granted master's arready is high this cycle
// ADDR  | present latched address to the selected slave
// DATA  | forward slave R channel to the granted master

module ysyx_23060236_rd_xbar #(
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] s0_araddr,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    output logic [31:0] s1_araddr,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rvalid,
    output logic        s1_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        gnt;
    logic        last;
    logic        sel;
    logic [31:0] addr;

    logic        arb_gnt;
    logic [31:0] req_addr;
    logic        ar_hs;
    logic        r_hs;
    logic        s_arready_sel;
    logic        s_rvalid_sel;
    logic [31:0] s_rdata_sel;
    logic [1:0]  s_rresp_sel;
    logic        m_rready_gnt;

    // A lone requester wins outright; on a tie the master not served last wins.
    assign arb_gnt  = (m0_arvalid & m1_arvalid) ? ~last : m1_arvalid;
    assign req_addr = arb_gnt ? m1_araddr : m0_araddr;
    // Gated by reset so arready stays low while reset is held.
    assign ar_hs    = reset & (state == IDLE) & (m0_arvalid | m1_arvalid);

    assign s_arready_sel = sel ? s1_arready : s0_arready;
    assign s_rvalid_sel  = sel ? s1_rvalid  : s0_rvalid;
    assign s_rdata_sel   = sel ? s1_rdata   : s0_rdata;
    assign s_rresp_sel   = sel ? s1_rresp   : s0_rresp;
    assign m_rready_gnt  = gnt ? m1_rready  : m0_rready;

    assign r_hs = (state == DATA) & s_rvalid_sel & m_rready_gnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            sel   <= 1'b0;
            addr  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (ar_hs) begin
                gnt  <= arb_gnt;
                sel  <= ((req_addr & CLINT_MASK) == CLINT_BASE);
                addr <= req_addr;
            end
            if (r_hs) begin
                last <= gnt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs)         state_nxt = ADDR;
            ADDR:    if (s_arready_sel) state_nxt = DATA;
            DATA:    if (r_hs)          state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rdata   = 32'h0;
        m1_rdata   = 32'h0;
        m0_rresp   = 2'b00;
        m1_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        s0_araddr  = 32'h0;
        s1_araddr  = 32'h0;
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        s0_rready  = 1'b0;
        s1_rready  = 1'b0;

        m0_arready = ar_hs & ~arb_gnt;
        m1_arready = ar_hs & arb_gnt;

        if (state == ADDR) begin
            if (sel) begin
                s1_arvalid = 1'b1;
                s1_araddr  = addr;
            end else begin
                s0_arvalid = 1'b1;
                s0_araddr  = addr;
            end
        end

        if (state == DATA) begin
            if (gnt) begin
                m1_rvalid = s_rvalid_sel;
                m1_rdata  = s_rdata_sel;
                m1_rresp  = s_rresp_sel;
            end else begin
                m0_rvalid = s_rvalid_sel;
                m0_rdata  = s_rdata_sel;
                m0_rresp  = s_rresp_sel;
            end
            if (sel) begin
                s1_rready = m_rready_gnt;
            end else begin
                s0_rready = m_rready_gnt;
            end
        end
    end

endmodule
